// File: rtl/axi_pkg.sv
// Shared AXI encodings and channel FSM state types for the RAM responder.
package axi_pkg;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_SIZE_W = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
endpackage

// File: rtl/axi_ram_responder_if.sv
// AXI4 bus (single ID bit) between the SoC memory master and the RAM responder.
interface axi_ram_responder_if
    import axi_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic                  awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [AXI_LEN_W-1:0]  awlen;
    logic [AXI_SIZE_W-1:0] awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic                  bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic                  arid;
    logic [ADDR_W-1:0]     araddr;
    logic [AXI_LEN_W-1:0]  arlen;
    logic [AXI_SIZE_W-1:0] arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic                  rid;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/iob_ram_2p.sv
// Two-port RAM: byte-enabled write port, registered read port, read-first on collision.
module iob_ram_2p #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic                clk,
    input  logic                w_en,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [DATA_W-1:0]   r_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset branch; contents must survive rst and a
    // reset loop over every word would stop the array mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (w_strb[b]) mem[w_addr][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
        if (r_en) r_data <= mem[r_addr];
    end
endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by a 2-port RAM; write and read channels run as independent FSMs.
module axi_ram_responder
    import axi_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 14
) (
    input logic                clk,
    input logic                rst,
    axi_ram_responder_if.slave s_axi
);
    localparam int BYTE_W = $clog2(DATA_W/8);

    // WRAP bursts advance exactly like INCR.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [AXI_SIZE_W-1:0] size,
                                                    input logic [1:0] burst);
        if (burst == BURST_FIXED) return addr;
        return addr + (ADDR_W'(1) << size);
    endfunction

    function automatic logic [MEM_ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr[MEM_ADDR_W+BYTE_W-1:BYTE_W];
    endfunction

    w_state_e              w_state, w_state_nxt;
    logic                  w_id, w_err;
    logic [ADDR_W-1:0]     w_addr;
    logic [AXI_LEN_W-1:0]  w_len, w_cnt;
    logic [AXI_SIZE_W-1:0] w_size;
    logic [1:0]            w_burst;
    logic                  aw_hs, w_hs, b_hs, w_last_beat;
    logic                  awready_d, wready_d, bvalid_d;

    assign aw_hs       = s_axi.awvalid & s_axi.awready;
    assign w_hs        = s_axi.wvalid & s_axi.wready;
    assign b_hs        = s_axi.bvalid & s_axi.bready;
    assign w_last_beat = (w_cnt == w_len);

    // NOTE: handshake outputs are registered from the next state, so they read 0
    // throughout rst and only rise on the first clock after rst falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
        end else begin
            w_state       <= w_state_nxt;
            s_axi.awready <= awready_d;
            s_axi.wready  <= wready_d;
            s_axi.bvalid  <= bvalid_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        awready_d = (w_state_nxt == W_IDLE);
        wready_d  = (w_state_nxt == W_DATA);
        bvalid_d  = (w_state_nxt == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_id <= 1'b0;  w_addr <= '0;  w_len <= '0;  w_size <= '0;
            w_burst <= BURST_FIXED;  w_cnt <= '0;  w_err <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= s_axi.awid;
            w_addr  <= s_axi.awaddr;
            w_len   <= s_axi.awlen;
            w_size  <= s_axi.awsize;
            w_burst <= s_axi.awburst;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_cnt  <= w_cnt + 1'b1;
            if (s_axi.wlast != w_last_beat) w_err <= 1'b1;
        end
    end

    assign s_axi.bid   = w_id;
    assign s_axi.bresp = (s_axi.bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

    r_state_e              r_state, r_state_nxt;
    logic                  r_id;
    logic [ADDR_W-1:0]     r_addr, r_addr_nxt;
    logic [AXI_LEN_W-1:0]  r_len, r_cnt;
    logic [AXI_SIZE_W-1:0] r_size;
    logic [1:0]            r_burst;
    logic                  ar_hs, r_hs, r_last_beat;
    logic                  arready_d, rvalid_d;
    logic                  ram_r_en;
    logic [MEM_ADDR_W-1:0] ram_r_addr;
    logic [DATA_W-1:0]     ram_r_data;

    assign ar_hs       = s_axi.arvalid & s_axi.arready;
    assign r_hs        = s_axi.rvalid & s_axi.rready;
    assign r_last_beat = (r_cnt == r_len);
    assign r_addr_nxt  = next_addr(r_addr, r_size, r_burst);

    // RAM only advances on AR or R handshakes, so rdata holds during a stall.
    assign ram_r_en   = ar_hs | r_hs;
    assign ram_r_addr = ar_hs ? word_idx(s_axi.araddr) : word_idx(r_addr_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
        end else begin
            r_state       <= r_state_nxt;
            s_axi.arready <= arready_d;
            s_axi.rvalid  <= rvalid_d;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_FETCH;
            R_FETCH: r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        arready_d = (r_state_nxt == R_IDLE);
        rvalid_d  = (r_state_nxt == R_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id <= 1'b0;  r_addr <= '0;  r_len <= '0;  r_size <= '0;
            r_burst <= BURST_FIXED;  r_cnt <= '0;
        end else if (ar_hs) begin
            r_id    <= s_axi.arid;
            r_addr  <= s_axi.araddr;
            r_len   <= s_axi.arlen;
            r_size  <= s_axi.arsize;
            r_burst <= s_axi.arburst;
            r_cnt   <= '0;
        end else if (r_hs) begin
            r_addr <= r_addr_nxt;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign s_axi.rid   = r_id;
    assign s_axi.rdata = ram_r_data;
    assign s_axi.rresp = RESP_OKAY;
    assign s_axi.rlast = s_axi.rvalid & r_last_beat;

    iob_ram_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk    (clk),
        .w_en   (w_hs),
        .w_strb (s_axi.wstrb),
        .w_addr (word_idx(w_addr)),
        .w_data (s_axi.wdata),
        .r_en   (ram_r_en),
        .r_addr (ram_r_addr),
        .r_data (ram_r_data)
    );
endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomized self-checking bench for axi_ram_responder against a byte-level memory model.
module tb_axi_ram_responder;
    import axi_pkg::*;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 16384;
    localparam int TIMEOUT   = 50;

    logic clk;
    logic rst;

    axi_ram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_ram_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (14)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference memory: data plus a mask of bytes that have ever been written.
    logic [31:0] mem_model   [MEM_WORDS];
    logic [31:0] known_model [MEM_WORDS];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int word_of(input logic [23:0] addr);
        return (int'(addr) / 4) % MEM_WORDS;
    endfunction

    function automatic logic [255:0] good_last(input int len);
        logic [255:0] v;
        v = '0;
        v[len] = 1'b1;
        return v;
    endfunction

    task automatic axi_write(input logic id, input logic [23:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] data [$], input logic [3:0] strb [$],
                             input logic [255:0] wlast_vec, input int gap_pct,
                             output logic [1:0] resp_seen);
        logic [1:0]  exp_resp;
        logic [23:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          n, idx;
        exp_resp = RESP_OKAY;
        a = addr;
        @(negedge clk);
        bus.awid = id;  bus.awaddr = addr;  bus.awlen = 8'(len);
        bus.awsize = size;  bus.awburst = burst;  bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < TIMEOUT) begin @(negedge clk); n++; end
        check("aw_ready", bus.awready, 1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                bus.wvalid = 1'b0;
                @(negedge clk);
            end
            d = data[i];
            s = strb[i];
            bus.wvalid = 1'b1;  bus.wdata = d;  bus.wstrb = s;  bus.wlast = wlast_vec[i];
            n = 0;
            while (!bus.wready && n < TIMEOUT) begin @(negedge clk); n++; end
            check("w_ready", bus.wready, 1);
            idx = word_of(a);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    mem_model[idx][b*8 +: 8]   = d[b*8 +: 8];
                    known_model[idx][b*8 +: 8] = 8'hFF;
                end
            end
            if (wlast_vec[i] != (i == len)) exp_resp = RESP_SLVERR;
            if (burst != BURST_FIXED) a = a + (24'd1 << size);
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        check("b_valid_latency", bus.bvalid, 1);
        check("b_resp", bus.bresp, exp_resp);
        check("b_id", bus.bid, id);
        resp_seen = bus.bresp;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("b_valid_clear", bus.bvalid, 0);
    endtask

    // mode 0: rready held high, 1: rready pattern 1,0,0 repeating, 2: random rready.
    task automatic axi_read(input logic id, input logic [23:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode,
                            output logic [31:0] first_data);
        logic [31:0] exp_data [256];
        logic [31:0] exp_mask [256];
        logic [31:0] held;
        logic [23:0] a;
        logic        rr, stalled;
        int          n, beat, cyc;
        first_data = '0;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            exp_data[i] = mem_model[word_of(a)];
            exp_mask[i] = known_model[word_of(a)];
            if (burst != BURST_FIXED) a = a + (24'd1 << size);
        end
        @(negedge clk);
        bus.arid = id;  bus.araddr = addr;  bus.arlen = 8'(len);
        bus.arsize = size;  bus.arburst = burst;  bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < TIMEOUT) begin @(negedge clk); n++; end
        check("ar_ready", bus.arready, 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("r_fetch_gap", bus.rvalid, 0);
        @(negedge clk);
        check("r_first_latency", bus.rvalid, 1);
        beat = 0;  cyc = 0;  stalled = 1'b0;  held = '0;
        while (beat <= len && cyc < 4 * (len + 1) + TIMEOUT) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 3 == 0);
                default: rr = 1'($urandom_range(1));
            endcase
            bus.rready = rr;
            if (mode == 0) check("r_throughput", bus.rvalid, 1);
            if (bus.rvalid) begin
                if (stalled) check("r_stable", bus.rdata, held);
                check("r_data", bus.rdata & exp_mask[beat], exp_data[beat] & exp_mask[beat]);
                check("r_last", bus.rlast, (beat == len));
                check("r_id", bus.rid, id);
                if (beat == 0) first_data = bus.rdata;
                if (rr) begin
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = bus.rdata;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 1'b0;
        check("r_beat_count", beat, len + 1);
        check("r_idle_after_last", bus.rvalid, 0);
    endtask

    logic [31:0] dq [$];
    logic [3:0]  sq [$];
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [255:0] lv;
    logic [23:0] raddr;
    int          rlen, beats, n;
    logic [2:0]  rsize;
    logic [1:0]  rburst;
    logic        rid_v;

    initial begin
        foreach (known_model[i]) begin
            known_model[i] = '0;
            mem_model[i]   = '0;
        end
        rst = 1'b1;
        bus.awid = 0;  bus.awaddr = '0;  bus.awlen = '0;  bus.awsize = '0;  bus.awburst = '0;
        bus.awvalid = 0;  bus.wdata = '0;  bus.wstrb = '0;  bus.wlast = 0;  bus.wvalid = 0;
        bus.bready = 0;  bus.arid = 0;  bus.araddr = '0;  bus.arlen = '0;  bus.arsize = '0;
        bus.arburst = '0;  bus.arvalid = 0;  bus.rready = 0;

        // Reset state and first ready cycle.
        repeat (3) @(negedge clk);
        check("rst_awready", bus.awready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rlast", bus.rlast, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_rresp", bus.rresp, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", bus.awready, 1);
        check("post_rst_arready", bus.arready, 1);

        // INCR burst write and full-rate readback.
        dq = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        sq = {4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(1'b1, 24'h100, 3, 3'd2, BURST_INCR, dq, sq, good_last(3), 0, resp);
        axi_read(1'b1, 24'h100, 3, 3'd2, BURST_INCR, 0, rd);
        check("incr_first_beat", rd, 32'hA0);

        // Partial strobe merge.
        dq = {32'h11223344};  sq = {4'hF};
        axi_write(1'b0, 24'h0, 0, 3'd2, BURST_INCR, dq, sq, good_last(0), 0, resp);
        dq = {32'hDEADBEEF};  sq = {4'b0011};
        axi_write(1'b0, 24'h0, 0, 3'd2, BURST_INCR, dq, sq, good_last(0), 0, resp);
        axi_read(1'b0, 24'h0, 0, 3'd2, BURST_INCR, 0, rd);
        check("strobe_merge", rd, 32'h1122BEEF);

        // wlast on the wrong beat, then a clean burst.
        dq = {32'h1, 32'h2};  sq = {4'hF, 4'hF};
        lv = '0;  lv[0] = 1'b1;
        axi_write(1'b1, 24'h200, 1, 3'd2, BURST_INCR, dq, sq, lv, 0, resp);
        check("wlast_err_resp", resp, RESP_SLVERR);
        axi_write(1'b1, 24'h200, 1, 3'd2, BURST_INCR, dq, sq, good_last(1), 0, resp);
        check("wlast_ok_resp", resp, RESP_OKAY);

        // Stalled read concurrent with an unrelated write.
        dq.delete();  sq.delete();
        for (int i = 0; i < 8; i++) begin dq.push_back(32'h5000 + i); sq.push_back(4'hF); end
        axi_write(1'b0, 24'h800, 7, 3'd2, BURST_INCR, dq, sq, good_last(7), 0, resp);
        fork
            axi_read(1'b0, 24'h800, 7, 3'd2, BURST_INCR, 1, rd);
            begin
                dq = {32'hC0, 32'hC1, 32'hC2, 32'hC3};
                sq = {4'hF, 4'hF, 4'hF, 4'hF};
                axi_write(1'b1, 24'h2000, 3, 3'd2, BURST_INCR, dq, sq, good_last(3), 10, resp);
            end
        join
        check("stall_first_beat", rd, 32'h5000);
        axi_read(1'b1, 24'h2000, 3, 3'd2, BURST_INCR, 2, rd);
        check("concurrent_write_first", rd, 32'hC0);

        // Reset in the middle of an 8-beat read.
        @(negedge clk);
        bus.arid = 0;  bus.araddr = 24'h800;  bus.arlen = 8'd7;  bus.arsize = 3'd2;
        bus.arburst = BURST_INCR;  bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < TIMEOUT) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        beats = 0;  n = 0;
        while (beats < 3 && n < TIMEOUT) begin
            if (bus.rvalid) beats++;
            @(negedge clk);
            n++;
        end
        check("pre_rst_beats", beats, 3);
        check("pre_rst_rvalid", bus.rvalid, 1);
        rst = 1'b1;
        bus.rready = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", bus.rvalid, 0);
        check("mid_rst_rlast", bus.rlast, 0);
        check("mid_rst_arready", bus.arready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("re_rst_arready", bus.arready, 1);
        check("re_rst_awready", bus.awready, 1);
        axi_read(1'b0, 24'h800, 7, 3'd2, BURST_INCR, 0, rd);
        check("ram_kept_over_rst", rd, 32'h5000);

        // Maximum-length burst.
        dq.delete();  sq.delete();
        for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
        axi_write(1'b0, 24'h4000, 255, 3'd2, BURST_INCR, dq, sq, good_last(255), 0, resp);
        axi_read(1'b0, 24'h4000, 255, 3'd2, BURST_INCR, 0, rd);

        // Random bursts: sizes, burst types, aliasing addresses, strobes, wlast errors.
        for (int t = 0; t < 24; t++) begin
            raddr  = 24'($urandom);
            rlen   = $urandom_range(15);
            rsize  = 3'($urandom_range(2));
            rburst = 2'($urandom_range(2));
            rid_v  = 1'($urandom_range(1));
            dq.delete();  sq.delete();
            for (int i = 0; i <= rlen; i++) begin
                dq.push_back($urandom);
                sq.push_back(4'($urandom));
            end
            lv = good_last(rlen);
            if ($urandom_range(4) == 0) begin
                n = $urandom_range(rlen);
                lv[n] = ~lv[n];
            end
            axi_write(rid_v, raddr, rlen, rsize, rburst, dq, sq, lv, 20, resp);
            axi_read(~rid_v, raddr, rlen, rsize, rburst, $urandom_range(2), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
